mem_port_arbiter: RTL and testbench

- Shares the single core memory port between the instruction-fetch unit (IFU, read-only) and the load/store unit (LSU, read/write).
- Needed once the core moves to a multi-cycle/bus memory model.
- Runs one transaction at a time: arbitrate, latch request, issue downstream, wait for response, route response back to its owner.
- Includes a response-timeout watchdog so a dead slave cannot hang the core.

---
 rtl/mem_port_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between IFU (read-only) and LSU, one transaction at a time, with a response watchdog.
// Optional macro MEM_ARB_ROUND_ROBIN_EN: alternate grants under contention instead of fixed LSU priority.
`default_nettype none

module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ifu_req_valid,
  output logic                  ifu_req_ready,
  input  logic [ADDR_W-1:0]     ifu_req_addr,
  output logic                  ifu_resp_valid,
  output logic [DATA_W-1:0]     ifu_resp_rdata,
  output logic                  ifu_resp_err,
  input  logic                  lsu_req_valid,
  output logic                  lsu_req_ready,
  input  logic [ADDR_W-1:0]     lsu_req_addr,
  input  logic                  lsu_req_wen,
  input  logic [DATA_W-1:0]     lsu_req_wdata,
  input  logic [DATA_W/8-1:0]   lsu_req_wmask,
  output logic                  lsu_resp_valid,
  output logic [DATA_W-1:0]     lsu_resp_rdata,
  output logic                  lsu_resp_err,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_W-1:0]     mem_req_addr,
  output logic                  mem_req_wen,
  output logic [DATA_W-1:0]     mem_req_wdata,
  output logic [DATA_W/8-1:0]   mem_req_wmask,
  input  logic                  mem_resp_valid,
  input  logic [DATA_W-1:0]     mem_resp_rdata,
  input  logic                  mem_resp_err,
  output logic                  busy
);

  localparam int               MASK_W   = DATA_W / 8;
  localparam int               CNT_W    = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  logic [1:0]        state_q, state_d;
  logic              owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wen_q, wen_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [MASK_W-1:0] wmask_q, wmask_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ifu_rv_q, ifu_rv_d, ifu_err_q, ifu_err_d;
  logic              lsu_rv_q, lsu_rv_d, lsu_err_q, lsu_err_d;
  logic [DATA_W-1:0] ifu_rdata_q, ifu_rdata_d, lsu_rdata_q, lsu_rdata_d;
  logic              grant_lsu, grant_ifu;
  logic              resp_fire;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_lsu_q, last_lsu_d;

  // Under contention the requester that did not win last time gets the port.
  assign grant_lsu  = lsu_req_valid & ~(ifu_req_valid & last_lsu_q);
  assign last_lsu_d = (state_q == S_IDLE && (grant_lsu || grant_ifu)) ? grant_lsu : last_lsu_q;

  always_ff @(posedge clk) begin
    if (reset) last_lsu_q <= OWN_IFU;
    else       last_lsu_q <= last_lsu_d;
  end
`else
  assign grant_lsu = lsu_req_valid;
`endif
  assign grant_ifu = ifu_req_valid & ~grant_lsu;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_IFU;
      addr_q      <= '0;
      wen_q       <= 1'b0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      cnt_q       <= '0;
      ifu_rv_q    <= 1'b0;
      ifu_rdata_q <= '0;
      ifu_err_q   <= 1'b0;
      lsu_rv_q    <= 1'b0;
      lsu_rdata_q <= '0;
      lsu_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      wen_q       <= wen_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
      cnt_q       <= cnt_d;
      ifu_rv_q    <= ifu_rv_d;
      ifu_rdata_q <= ifu_rdata_d;
      ifu_err_q   <= ifu_err_d;
      lsu_rv_q    <= lsu_rv_d;
      lsu_rdata_q <= lsu_rdata_d;
      lsu_err_q   <= lsu_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    wen_d       = wen_q;
    wdata_d     = wdata_q;
    wmask_d     = wmask_q;
    cnt_d       = cnt_q;
    resp_fire   = 1'b0;
    resp_rdata  = '0;
    resp_err    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (grant_lsu) begin
          owner_d = OWN_LSU;
          addr_d  = lsu_req_addr;
          wen_d   = lsu_req_wen;
          wdata_d = lsu_req_wdata;
          wmask_d = lsu_req_wen ? lsu_req_wmask : '0;
          state_d = S_REQ;
        end else if (grant_ifu) begin
          owner_d = OWN_IFU;
          addr_d  = ifu_req_addr;
          wen_d   = 1'b0;
          wdata_d = '0;
          wmask_d = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (mem_req_ready) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        // A real response wins over the watchdog when both land on the last cycle.
        if (mem_resp_valid) begin
          resp_fire  = 1'b1;
          resp_rdata = wen_q ? '0 : mem_resp_rdata;
          resp_err   = mem_resp_err;
          state_d    = S_IDLE;
        end else if (cnt_q >= CNT_LAST) begin
          resp_fire  = 1'b1;
          resp_err   = 1'b1;
          state_d    = S_IDLE;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    ifu_rv_d    = resp_fire & (owner_q == OWN_IFU);
    lsu_rv_d    = resp_fire & (owner_q == OWN_LSU);
    ifu_rdata_d = ifu_rv_d ? resp_rdata : ifu_rdata_q;
    ifu_err_d   = ifu_rv_d ? resp_err : ifu_err_q;
    lsu_rdata_d = lsu_rv_d ? resp_rdata : lsu_rdata_q;
    lsu_err_d   = lsu_rv_d ? resp_err : lsu_err_q;
  end

  always_comb begin
    ifu_req_ready = 1'b0;
    lsu_req_ready = 1'b0;
    mem_req_valid = 1'b0;
    busy          = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        ifu_req_ready = grant_ifu;
        lsu_req_ready = grant_lsu;
      end
      S_REQ:   mem_req_valid = 1'b1;
      default: ;
    endcase
  end

  assign mem_req_addr   = addr_q;
  assign mem_req_wen    = wen_q;
  assign mem_req_wdata  = wdata_q;
  assign mem_req_wmask  = wmask_q;
  assign ifu_resp_valid = ifu_rv_q;
  assign ifu_resp_rdata = ifu_rdata_q;
  assign ifu_resp_err   = ifu_err_q;
  assign lsu_resp_valid = lsu_rv_q;
  assign lsu_resp_rdata = lsu_rdata_q;
  assign lsu_resp_err   = lsu_err_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vector table, hand sequences and randomized traffic against a transaction-timing model.
`timescale 1ns/1ps
`default_nettype none

module tb_mem_port_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_err;
  logic [31:0] ifu_req_addr, ifu_resp_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_req_wen, lsu_resp_valid, lsu_resp_err;
  logic [31:0] lsu_req_addr, lsu_req_wdata, lsu_resp_rdata;
  logic [3:0]  lsu_req_wmask;
  logic        mem_req_valid, mem_req_ready, mem_req_wen, mem_resp_valid, mem_resp_err, busy;
  logic [31:0] mem_req_addr, mem_req_wdata, mem_resp_rdata;
  logic [3:0]  mem_req_wmask;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_rdata(ifu_resp_rdata), .ifu_resp_err(ifu_resp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
    .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_rdata(lsu_resp_rdata), .lsu_resp_err(lsu_resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata), .mem_resp_err(mem_resp_err),
    .busy(busy)
  );

  typedef struct {
    bit          lsu;
    logic [31:0] addr;
    bit          wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    int          rd;      // cycles mem_req_ready stays low
    int          sd;      // WAIT cycles before response; >= TO means never
    logic [31:0] rdata;
    bit          err_in;
    logic [31:0] x_rdata;
    bit          x_err;
    int          x_lat;   // handshake cycle to resp_valid cycle
  } vec_t;

  vec_t tbl[6];

  int n_tests = 0, n_fail = 0, cyc = 0;

  // Transaction model: one outstanding transaction described by its handshake cycle and slave plan.
  bit          pending = 0, m_owner = 0, m_wen = 0, m_err_in = 0, m_last_lsu = 0;
  logic [31:0] m_addr = 0, m_wdata = 0, m_rdata = 0;
  logic [3:0]  m_wmask = 0;
  int          m_hs = -100, m_rd = 0, m_sd = 0, m_w = -100, m_e = -100;
  logic [31:0] x_ifu_rdata = 0, x_lsu_rdata = 0;
  bit          x_ifu_err = 0, x_lsu_err = 0;

  bit          rand_mode = 0, strays = 0, force_stray = 0, use_plan = 1;
  int          p_rd = 0, p_sd = 0;
  logic [31:0] p_rdata = 0;
  bit          p_err = 0;
  bit          hs_ifu = 0, hs_lsu = 0;
  int          obs_ifu_cyc = -1, obs_lsu_cyc = -1;
  logic [31:0] obs_ifu_rdata = 0, obs_lsu_rdata = 0;
  bit          obs_ifu_err = 0, obs_lsu_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive slave side, compare at mid-cycle, advance model, cross the edge.
  task automatic tick();
    bit in_req, in_wait, g_lsu, g_ifu, x_rv_i, x_rv_l;
    in_req  = pending && cyc > m_hs && cyc <= m_hs + 1 + m_rd;
    in_wait = pending && cyc >= m_w && cyc < m_e;
    if (in_req) mem_req_ready = (cyc == m_hs + 1 + m_rd);
    else        mem_req_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b0;
    if (in_wait) begin
      mem_resp_valid = (m_sd < TO) && (cyc == m_w + m_sd);
      mem_resp_rdata = m_rdata;
      mem_resp_err   = m_err_in;
    end else begin
      mem_resp_valid = force_stray || (strays && $urandom_range(0, 3) == 0);
      mem_resp_rdata = $urandom;
      mem_resp_err   = 1'($urandom_range(0, 1));
    end
    if (rand_mode) begin
      if (!ifu_req_valid && $urandom_range(0, 2) == 0) begin
        ifu_req_valid = 1'b1;
        ifu_req_addr  = $urandom;
      end
      if (!lsu_req_valid && $urandom_range(0, 2) == 0) begin
        lsu_req_valid = 1'b1;
        lsu_req_addr  = $urandom;
        lsu_req_wen   = 1'($urandom_range(0, 1));
        lsu_req_wdata = $urandom;
        lsu_req_wmask = 4'($urandom);
      end
    end
    #4;
    x_rv_i = pending && cyc == m_e && !m_owner;
    x_rv_l = pending && cyc == m_e && m_owner;
    if (x_rv_i) begin
      x_ifu_rdata = (m_sd >= TO) ? 32'h0 : m_rdata;
      x_ifu_err   = (m_sd >= TO) ? 1'b1 : m_err_in;
    end
    if (x_rv_l) begin
      x_lsu_rdata = (m_sd >= TO || m_wen) ? 32'h0 : m_rdata;
      x_lsu_err   = (m_sd >= TO) ? 1'b1 : m_err_in;
    end
    if (x_rv_i || x_rv_l) pending = 0;
    g_lsu = 0;
    g_ifu = 0;
    if (!pending) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      g_lsu = (lsu_req_valid && ifu_req_valid) ? !m_last_lsu : lsu_req_valid;
`else
      g_lsu = lsu_req_valid;
`endif
      g_ifu = ifu_req_valid && !g_lsu;
    end
    chk("ifu_req_ready", 64'(ifu_req_ready), 64'(g_ifu));
    chk("lsu_req_ready", 64'(lsu_req_ready), 64'(g_lsu));
    chk("mem_req_valid", 64'(mem_req_valid), 64'(in_req));
    if (in_req) begin
      chk("mem_req_addr", 64'(mem_req_addr), 64'(m_addr));
      chk("mem_req_wen", 64'(mem_req_wen), 64'(m_wen));
      chk("mem_req_wmask", 64'(mem_req_wmask), 64'(m_wmask));
      if (m_wen || !m_owner) chk("mem_req_wdata", 64'(mem_req_wdata), 64'(m_wdata));
    end
    chk("busy", 64'(busy), 64'(pending && cyc > m_hs));
    chk("ifu_resp_valid", 64'(ifu_resp_valid), 64'(x_rv_i));
    chk("lsu_resp_valid", 64'(lsu_resp_valid), 64'(x_rv_l));
    chk("ifu_resp_rdata", 64'(ifu_resp_rdata), 64'(x_ifu_rdata));
    chk("ifu_resp_err", 64'(ifu_resp_err), 64'(x_ifu_err));
    chk("lsu_resp_rdata", 64'(lsu_resp_rdata), 64'(x_lsu_rdata));
    chk("lsu_resp_err", 64'(lsu_resp_err), 64'(x_lsu_err));
    if (ifu_resp_valid) begin
      obs_ifu_cyc = cyc; obs_ifu_rdata = ifu_resp_rdata; obs_ifu_err = ifu_resp_err;
    end
    if (lsu_resp_valid) begin
      obs_lsu_cyc = cyc; obs_lsu_rdata = lsu_resp_rdata; obs_lsu_err = lsu_resp_err;
    end
    hs_ifu = g_ifu;
    hs_lsu = g_lsu;
    if (g_lsu || g_ifu) begin
      pending    = 1;
      m_hs       = cyc;
      m_owner    = g_lsu;
      m_last_lsu = g_lsu;
      m_addr     = g_lsu ? lsu_req_addr : ifu_req_addr;
      m_wen      = g_lsu && lsu_req_wen;
      m_wdata    = m_wen ? lsu_req_wdata : 32'h0;
      m_wmask    = m_wen ? lsu_req_wmask : 4'h0;
      if (use_plan) begin
        m_rd = p_rd; m_sd = p_sd; m_rdata = p_rdata; m_err_in = p_err;
      end else begin
        m_rd = $urandom_range(0, 3); m_sd = $urandom_range(0, 5);
        m_rdata = $urandom; m_err_in = ($urandom_range(0, 3) == 0);
      end
      m_w = m_hs + 2 + m_rd;
      m_e = (m_sd < TO) ? m_w + m_sd + 1 : m_w + TO;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rand_mode) begin
      if (hs_ifu) ifu_req_valid = 1'b0;
      if (hs_lsu) lsu_req_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ifu_req_valid = 0; lsu_req_valid = 0; mem_req_ready = 0; mem_resp_valid = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc++;
    pending = 0; m_last_lsu = 0;
    x_ifu_rdata = 0; x_lsu_rdata = 0; x_ifu_err = 0; x_lsu_err = 0;
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int hs_cyc, got_cyc;
    logic [31:0] got_rdata;
    bit got_err;
    p_rd = v.rd; p_sd = v.sd; p_rdata = v.rdata; p_err = v.err_in;
    if (v.lsu) begin
      lsu_req_valid = 1; lsu_req_addr = v.addr; lsu_req_wen = v.wen;
      lsu_req_wdata = v.wdata; lsu_req_wmask = v.wmask;
    end else begin
      ifu_req_valid = 1; ifu_req_addr = v.addr;
    end
    obs_ifu_cyc = -1; obs_lsu_cyc = -1;
    hs_cyc = cyc;
    tick();
    chk({nm, "_accept"}, 64'(v.lsu ? hs_lsu : hs_ifu), 64'(1));
    ifu_req_valid = 0; lsu_req_valid = 0;
    for (int k = 0; k < 20 && (v.lsu ? obs_lsu_cyc : obs_ifu_cyc) < 0; k++) tick();
    got_cyc   = v.lsu ? obs_lsu_cyc : obs_ifu_cyc;
    got_rdata = v.lsu ? obs_lsu_rdata : obs_ifu_rdata;
    got_err   = v.lsu ? obs_lsu_err : obs_ifu_err;
    chk({nm, "_resp_seen"}, 64'(got_cyc >= 0), 64'(1));
    chk({nm, "_latency"}, 64'(got_cyc - hs_cyc), 64'(v.x_lat));
    chk({nm, "_rdata"}, 64'(got_rdata), 64'(v.x_rdata));
    chk({nm, "_err"}, 64'(got_err), 64'(v.x_err));
    chk({nm, "_other_quiet"}, 64'(v.lsu ? obs_ifu_cyc : obs_lsu_cyc), 64'(-1));
  endtask

  initial begin
    int hs_cyc;
    tbl[0] = '{0, 32'h80000000, 0, 32'h0, 4'h0, 0, 0, 32'h00100073, 0, 32'h00100073, 0, 3};
    tbl[1] = '{1, 32'h80000010, 1, 32'hDEADBEEF, 4'h1, 3, 0, 32'h12345678, 0, 32'h0, 0, 6};
    tbl[2] = '{1, 32'h80002000, 0, 32'h0, 4'hF, 0, 7, 32'h0, 0, 32'h0, 1, 6};
    tbl[3] = '{0, 32'h80000020, 0, 32'h0, 4'h0, 1, 2, 32'hCAFEF00D, 1, 32'hCAFEF00D, 1, 6};
    tbl[4] = '{0, 32'h80000024, 0, 32'h0, 4'h0, 0, 1, 32'h00000013, 0, 32'h00000013, 0, 4};
    tbl[5] = '{1, 32'h80001004, 0, 32'h0, 4'hF, 2, 3, 32'h0000A5A5, 0, 32'h0000A5A5, 0, 8};

    ifu_req_addr = 0; lsu_req_addr = 0; lsu_req_wen = 0; lsu_req_wdata = 0; lsu_req_wmask = 0;
    mem_resp_rdata = 0; mem_resp_err = 0;
    do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_mem_req_valid", 64'(mem_req_valid), 64'(0));
    chk("rst_mem_req_fields", 64'({mem_req_addr, mem_req_wen, mem_req_wmask}), 64'(0));
    chk("rst_resp_valid", 64'({ifu_resp_valid, lsu_resp_valid}), 64'(0));
    chk("rst_resp_data", 64'({ifu_resp_rdata, lsu_resp_rdata}), 64'(0));

    for (int i = 0; i < 6; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Timed-out transaction followed by a stray response two cycles later.
    run_vec(tbl[2], "timeout");
    tick();
    force_stray = 1;
    tick();
    force_stray = 0;
    chk("stray_idle", 64'(busy), 64'(0));
    chk("stray_no_resp", 64'({ifu_resp_valid, lsu_resp_valid}), 64'(0));
    repeat (2) tick();

    // Simultaneous requests: LSU first, IFU in the cycle the LSU response pulses.
    p_rd = 0; p_sd = 0; p_rdata = 32'h11111111; p_err = 0;
    ifu_req_valid = 1; ifu_req_addr = 32'h80000004;
    lsu_req_valid = 1; lsu_req_addr = 32'h80001000; lsu_req_wen = 0; lsu_req_wmask = 4'hF;
    obs_lsu_cyc = -1;
    tick();
    chk("cont_lsu_first", 64'(hs_lsu), 64'(1));
    lsu_req_valid = 0;
    hs_cyc = -1;
    for (int k = 0; k < 20 && hs_cyc < 0; k++) begin
      tick();
      if (hs_ifu) hs_cyc = cyc - 1;
    end
    chk("cont_ifu_after_resp", 64'(hs_cyc), 64'(obs_lsu_cyc));
    ifu_req_valid = 0;
    repeat (6) tick();

    // Back-to-back contention: the arbitration policy decides the second grant.
    ifu_req_valid = 1; lsu_req_valid = 1;
    tick();
    chk("cont2_first_lsu", 64'(hs_lsu), 64'(1));
    hs_cyc = -1;
    for (int k = 0; k < 20 && hs_cyc < 0; k++) begin
      tick();
      if (hs_ifu || hs_lsu) hs_cyc = cyc - 1;
    end
`ifdef MEM_ARB_ROUND_ROBIN_EN
    chk("cont2_second_ifu", 64'(hs_ifu), 64'(1));
`else
    chk("cont2_second_lsu", 64'(hs_lsu), 64'(1));
`endif
    ifu_req_valid = 0; lsu_req_valid = 0;
    repeat (6) tick();

    // Reset while waiting on a dead slave abandons the transaction.
    p_rd = 0; p_sd = 7; p_rdata = 0; p_err = 0;
    lsu_req_valid = 1; lsu_req_addr = 32'h80003000; lsu_req_wen = 0;
    tick();
    lsu_req_valid = 0;
    repeat (2) tick();
    chk("pre_reset_busy", 64'(busy), 64'(1));
    do_reset();
    chk("post_reset_busy", 64'(busy), 64'(0));
    chk("post_reset_resp", 64'({ifu_resp_valid, lsu_resp_valid}), 64'(0));
    chk("post_reset_mem_valid", 64'(mem_req_valid), 64'(0));
    chk("post_reset_rdata", 64'({ifu_resp_rdata, lsu_resp_rdata}), 64'(0));
    repeat (6) tick();
    run_vec(tbl[0], "after_reset");

    // Randomized traffic with stray responses and random slave timing.
    rand_mode = 1; strays = 1; use_plan = 0;
    repeat (3000) tick();
    rand_mode = 0; strays = 0;
    ifu_req_valid = 0; lsu_req_valid = 0;
    repeat (12) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
